// File: rtl/awb_gain_ctrl.sv
// awb_gain_ctrl: gray-world auto-white-balance gain controller (Q2.6 gains).
// Define AWB_GAIN_SMOOTH_EN to average each new R/B gain with the previous one.
module awb_gain_ctrl #(
  parameter int P_ACC_W = 32,
  parameter int P_FRAC  = 6,
  parameter int P_GMAX  = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_valid,
  input  logic [7:0] i_color_r,
  input  logic [7:0] i_color_g,
  input  logic [7:0] i_color_b,
  input  logic       i_start_frame_flag,
  input  logic       i_end_frame_flag,
  output logic [7:0] o_gain_r,
  output logic [7:0] o_gain_g,
  output logic [7:0] o_gain_b,
  output logic       o_gain_valid,
  output logic       o_busy
);
  localparam int W = P_ACC_W + 9;
  localparam logic [7:0] UNITY = 8'(1 << P_FRAC);
  localparam logic [7:0] GMAX = 8'(P_GMAX);
  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DIV_R, S_DIV_B, S_UPDATE} state_t;
  state_t state_q;
  logic [P_ACC_W-1:0] sum_r_q, sum_g_q, sum_b_q, sum_r_d, sum_g_d, sum_b_d, dsor;
  logic [W-1:0] rem_q, den_q;
  logic [7:0] quo_q, q_r_q, q_b_q, q_raw, q_fin, pix_r, pix_g, pix_b, new_r, new_b;
  logic [3:0] cnt_q;
  logic sat_q, sat_now, ge, restart;

  function automatic logic [P_ACC_W-1:0] sat_add(input logic [P_ACC_W-1:0] s, input logic [7:0] p);
    logic [P_ACC_W:0] t;
    t = {1'b0, s} + (P_ACC_W+1)'(p);
    return t[P_ACC_W] ? '1 : t[P_ACC_W-1:0];
  endfunction

  // Next accumulator values: a start without end (or leaving IDLE) restarts from this pixel.
  always_comb begin
    pix_r   = i_valid ? i_color_r : 8'd0;
    pix_g   = i_valid ? i_color_g : 8'd0;
    pix_b   = i_valid ? i_color_b : 8'd0;
    restart = (state_q == S_IDLE) || (i_start_frame_flag && !i_end_frame_flag);
    sum_r_d = restart ? P_ACC_W'(pix_r) : sat_add(sum_r_q, pix_r);
    sum_g_d = restart ? P_ACC_W'(pix_g) : sat_add(sum_g_q, pix_g);
    sum_b_d = restart ? P_ACC_W'(pix_b) : sat_add(sum_b_q, pix_b);
  end

  // Divider helpers: overflow pre-check, restoring step, clamp, and the gain write-back value.
  always_comb begin
    dsor    = (state_q == S_DIV_R) ? sum_r_q : sum_b_q;
    sat_now = (dsor == '0) || ((W'(sum_g_q) << P_FRAC) >= (W'(dsor) << 8));
    ge      = rem_q >= den_q;
    q_raw   = sat_q ? quo_q : {quo_q[6:0], ge};
    q_fin   = (q_raw > GMAX) ? GMAX : q_raw;
`ifdef AWB_GAIN_SMOOTH_EN
    new_r   = 8'((9'(o_gain_r) + 9'(q_r_q)) >> 1);
    new_b   = 8'((9'(o_gain_b) + 9'(q_b_q)) >> 1);
`else
    new_r   = q_r_q;
    new_b   = q_b_q;
`endif
  end

  // Control FSM with accumulators, shared 9-cycle divider and registered gain outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= S_IDLE;
      sum_r_q      <= '0;
      sum_g_q      <= '0;
      sum_b_q      <= '0;
      rem_q        <= '0;
      den_q        <= '0;
      quo_q        <= '0;
      q_r_q        <= '0;
      q_b_q        <= '0;
      cnt_q        <= '0;
      sat_q        <= 1'b0;
      o_gain_r     <= UNITY;
      o_gain_g     <= UNITY;
      o_gain_b     <= UNITY;
      o_gain_valid <= 1'b0;
    end else begin
      o_gain_valid <= 1'b0;
      case (state_q)
        S_IDLE: if (i_enable && i_start_frame_flag) begin
          state_q <= S_ACCUM;
          sum_r_q <= sum_r_d;
          sum_g_q <= sum_g_d;
          sum_b_q <= sum_b_d;
        end
        S_ACCUM: if (!i_enable) state_q <= S_IDLE;
        else begin
          sum_r_q <= sum_r_d;
          sum_g_q <= sum_g_d;
          sum_b_q <= sum_b_d;
          if (i_end_frame_flag) begin
            state_q <= S_DIV_R;
            cnt_q   <= '0;
          end
        end
        S_DIV_R, S_DIV_B: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd0) begin
            rem_q <= W'(sum_g_q) << P_FRAC;
            den_q <= W'(dsor) << 7;
            sat_q <= sat_now;
            quo_q <= sat_now ? GMAX : 8'd0;
          end else begin
            if (!sat_q && ge) rem_q <= rem_q - den_q;
            den_q <= den_q >> 1;
            quo_q <= q_raw;
          end
          if (cnt_q == 4'd8) begin
            cnt_q <= '0;
            if (state_q == S_DIV_R) begin
              q_r_q   <= q_fin;
              state_q <= S_DIV_B;
            end else begin
              q_b_q   <= q_fin;
              state_q <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          o_gain_r     <= new_r;
          o_gain_g     <= UNITY;
          o_gain_b     <= new_b;
          o_gain_valid <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy = state_q != S_IDLE;
endmodule
